pkt_flit_engine: RTL and testbench
==================================

PKT_FLIT_ENGINE -- requirements
Module: pkt_flit_engine

Interface
REQ-001 SHALL have parameter FlitDataW, default 32, payload bits per flit.
REQ-002 SHALL have parameter NumVc, default 3, number of virtual channels.
REQ-003 SHALL have parameter PktSzW, default 8, width of packet length in flits.
REQ-004 SHALL have ports: clk  in  1  clock; arst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: tx_valid in 1; tx_ready out 1; tx_data in FlitDataW; tx_vc in $clog2(NumVc); tx_pkt_sz in PktSzW, sampled on the first beat only.
REQ-006 SHALL have ports: noc_tx_valid out 1; noc_tx_ready in 1; noc_tx_flit out FlitDataW+2, type in [MSB:MSB-1]; noc_tx_vc out $clog2(NumVc).
REQ-007 SHALL have ports: noc_rx_valid in 1; noc_rx_ready out 1; noc_rx_flit in FlitDataW+2; noc_rx_vc in $clog2(NumVc).
REQ-008 SHALL have ports: rx_valid out 1; rx_ready in 1; rx_data out FlitDataW; rx_vc out $clog2(NumVc); rx_last out 1; rx_err out NumVc, sticky per VC; err_clr in NumVc, per-VC clear pulse.

Function
REQ-009 TX FSM SHALL have states IDLE and BURST; a beat transfers when tx_valid and tx_ready are both high.
REQ-010 In IDLE, a beat SHALL emit a HEAD flit, latch tx_vc, and load remaining = max(tx_pkt_sz,1)-1; remaining=0 -> stay IDLE (single-flit packet, HEAD only), else -> BURST.
REQ-011 In BURST, each beat SHALL emit BODY when remaining>1, TAIL when remaining==1, and decrement; TAIL -> IDLE.
REQ-012 In BURST, tx_vc SHALL be ignored; every flit uses the latched VC.
REQ-013 TX path SHALL pass through a 2-entry skid buffer: tx_ready = buffer not full; noc_tx_valid = buffer not empty; enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; latency tx beat -> noc_tx_valid = 1 cycle.
REQ-014 noc_tx_flit and noc_tx_vc SHALL stay stable while noc_tx_valid is high and noc_tx_ready is low.
REQ-015 RX path SHALL be a 1-entry registered stage: noc_rx_ready = !full || rx_ready; rx_data = flit payload with type bits stripped; rx_last = 1 for TAIL, or for a HEAD that closes its packet per REQ-010 sizing (FLIT_PKT_SZ_IN_HEAD_EN only).
REQ-016 Each VC SHALL track open/closed: HEAD opens (HEAD with size<=1 under the macro opens and closes); TAIL closes.
REQ-017 BODY or TAIL on a closed VC, or HEAD on an open VC, SHALL set rx_err[vc]; the flit SHALL still be forwarded; HEAD on an open VC re-opens it.
REQ-018 err_clr[i] and a same-cycle new error on VC i SHALL leave rx_err[i]=1 (set wins).
REQ-019 Flit type encoding 2'b11 SHALL set rx_err[vc] and be forwarded as a body flit.

Reset
REQ-020 On arst: TX FSM IDLE, remaining=0, skid buffer empty, RX stage empty, all VCs closed, rx_err=0; all valid outputs 0, tx_ready=1, noc_rx_ready=1, data outputs 0.
REQ-021 Reset mid-packet SHALL discard buffered flits; no TAIL is generated.

Configuration
REQ-022 With FLIT_PKT_SZ_IN_HEAD_EN defined, HEAD payload bits [FlitDataW-1:FlitDataW-PktSzW] SHALL be overwritten with max(tx_pkt_sz,1), and RX SHALL decode that field to close single-flit packets and count down remaining per VC, flagging rx_err on a TAIL/count mismatch.
REQ-023 Without the macro, HEAD payload SHALL be tx_data unchanged and RX closes packets on TAIL only.

Structure
REQ-024 Flit type enum (HEAD=2'b00, BODY=2'b01, TAIL=2'b10) and the TX FSM state enum SHALL live in ravenoc_pkg.
REQ-025 The skid buffer SHALL be a sub-module named flit_skid_buf, parametrised by width.

Verification
REQ-026 tx_pkt_sz=4, 4 beats on VC1, noc_tx_ready=1 -> types HEAD,BODY,BODY,TAIL, noc_tx_vc=1 each, one flit per cycle after 1-cycle latency.
REQ-027 tx_pkt_sz=0 and =1 -> single HEAD flit, FSM stays IDLE; macro on -> size field =1.
REQ-028 noc_tx_ready=0 for 5 cycles mid-packet -> tx_ready drops after 2 accepted beats, noc_tx_flit stable, no flit lost or duplicated.
REQ-029 RX BODY on closed VC2 -> rx_err=3'b100, flit forwarded; err_clr=3'b100 -> rx_err=0 next cycle; clear coincident with new error -> stays 1.
REQ-030 Interleaved RX packets on VC0/VC1 with rx_ready toggling -> correct rx_last per VC, no rx_err.
REQ-031 arst asserted after HEAD+BODY of a 4-flit packet -> all outputs at reset values; next packet starts with HEAD.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Shared flit-type and TX state encodings for the packet/flit engine.
package ravenoc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10,
        FLIT_RSVD = 2'b11
    } flit_type_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_BURST = 1'b1
    } tx_state_t;

endpackage

// File: rtl/flit_skid_buf.sv
// Two-entry registered FIFO decoupling the packetiser from NoC backpressure.
module flit_skid_buf #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic [Width-1:0] mem_q [2];
    logic             wrPtr_q;
    logic             rdPtr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rdPtr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry only moves on a pop, so the output holds steady under stall.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= in_data;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (pop) rdPtr_q <= ~rdPtr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pkt_flit_engine.sv
// Packet <-> flit engine: TX packetiser with skid buffer, RX stage with per-VC framing checks.
// Optional FLIT_PKT_SZ_IN_HEAD_EN carries the packet size in the HEAD payload MSBs.
module pkt_flit_engine
    import ravenoc_pkg::*;
#(
    parameter int FlitDataW = 32,
    parameter int NumVc     = 3,
    parameter int PktSzW    = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [FlitDataW-1:0]       tx_data,
    input  logic [$clog2(NumVc)-1:0]   tx_vc,
    input  logic [PktSzW-1:0]          tx_pkt_sz,
    output logic                       noc_tx_valid,
    input  logic                       noc_tx_ready,
    output logic [FlitDataW+1:0]       noc_tx_flit,
    output logic [$clog2(NumVc)-1:0]   noc_tx_vc,
    input  logic                       noc_rx_valid,
    output logic                       noc_rx_ready,
    input  logic [FlitDataW+1:0]       noc_rx_flit,
    input  logic [$clog2(NumVc)-1:0]   noc_rx_vc,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FlitDataW-1:0]       rx_data,
    output logic [$clog2(NumVc)-1:0]   rx_vc,
    output logic                       rx_last,
    output logic [NumVc-1:0]           rx_err,
    input  logic [NumVc-1:0]           err_clr
);

    localparam int VcW  = $clog2(NumVc);
    localparam int BufW = FlitDataW + 2 + VcW;

    tx_state_t             state_q, state_d;
    logic [PktSzW-1:0]     remaining_q, remaining_d;
    logic [VcW-1:0]        vcLatch_q, vcLatch_d;
    logic [PktSzW-1:0]     szEff;
    flit_type_t            txType;
    logic [FlitDataW-1:0]  txPayload;
    logic [VcW-1:0]        txVc;
    logic                  txBeat;
    logic                  bufInReady;

    assign szEff    = (tx_pkt_sz == '0) ? PktSzW'(1) : tx_pkt_sz;
    assign txBeat   = tx_valid && bufInReady;
    assign tx_ready = bufInReady;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        vcLatch_d   = vcLatch_q;
        txType      = FLIT_HEAD;
        txVc        = tx_vc;
        txPayload   = tx_data;
        case (state_q)
            TX_IDLE: begin
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
                txPayload[FlitDataW-1 -: PktSzW] = szEff;
`endif
                if (txBeat) begin
                    vcLatch_d   = tx_vc;
                    remaining_d = szEff - PktSzW'(1);
                    if (szEff != PktSzW'(1)) state_d = TX_BURST;
                end
            end
            TX_BURST: begin
                // Body beats ride on the VC captured with the HEAD.
                txVc   = vcLatch_q;
                txType = (remaining_q > PktSzW'(1)) ? FLIT_BODY : FLIT_TAIL;
                if (txBeat) begin
                    remaining_d = remaining_q - PktSzW'(1);
                    if (remaining_q <= PktSzW'(1)) state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= TX_IDLE;
            remaining_q <= '0;
            vcLatch_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            vcLatch_q   <= vcLatch_d;
        end
    end

    flit_skid_buf #(.Width(BufW)) u_skid (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (tx_valid),
        .in_ready  (bufInReady),
        .in_data   ({txType, txPayload, txVc}),
        .out_valid (noc_tx_valid),
        .out_ready (noc_tx_ready),
        .out_data  ({noc_tx_flit, noc_tx_vc})
    );

    flit_type_t            rxType;
    logic [FlitDataW-1:0]  rxPayload;
    logic                  rxAccept;
    logic                  rxLastNew;
    logic                  rxFull_q;
    logic [FlitDataW-1:0]  rxData_q;
    logic [VcW-1:0]        rxVc_q;
    logic                  rxLast_q;
    logic [NumVc-1:0]      open_q, open_d;
    logic [NumVc-1:0]      errSet;
    logic [NumVc-1:0]      rxErr_q;
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
    logic [PktSzW-1:0]     rxCnt_q [NumVc];
    logic [PktSzW-1:0]     rxCnt_d [NumVc];
    logic [PktSzW-1:0]     rxSize;
    assign rxSize = rxPayload[FlitDataW-1 -: PktSzW];
`endif

    assign rxType       = flit_type_t'(noc_rx_flit[FlitDataW+1:FlitDataW]);
    assign rxPayload    = noc_rx_flit[FlitDataW-1:0];
    assign noc_rx_ready = !rxFull_q || rx_ready;
    assign rxAccept     = noc_rx_valid && noc_rx_ready;
    assign rx_valid     = rxFull_q;
    assign rx_data      = rxData_q;
    assign rx_vc        = rxVc_q;
    assign rx_last      = rxLast_q;
    assign rx_err       = rxErr_q;

    // Framing errors are flagged but never block forwarding of the flit.
    always_comb begin
        open_d    = open_q;
        errSet    = '0;
        rxLastNew = (rxType == FLIT_TAIL);
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
        rxCnt_d = rxCnt_q;
        if (rxType == FLIT_HEAD && rxSize <= PktSzW'(1)) rxLastNew = 1'b1;
`endif
        for (int i = 0; i < NumVc; i++) begin
            if (rxAccept && noc_rx_vc == VcW'(i)) begin
                case (rxType)
                    FLIT_HEAD: begin
                        if (open_q[i]) errSet[i] = 1'b1;
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
                        open_d[i]  = (rxSize > PktSzW'(1));
                        rxCnt_d[i] = (rxSize > PktSzW'(1)) ? rxSize - PktSzW'(1) : '0;
`else
                        open_d[i] = 1'b1;
`endif
                    end
                    FLIT_BODY: begin
                        if (!open_q[i]) errSet[i] = 1'b1;
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
                        if (rxCnt_q[i] != '0) rxCnt_d[i] = rxCnt_q[i] - PktSzW'(1);
`endif
                    end
                    FLIT_TAIL: begin
                        if (!open_q[i]) errSet[i] = 1'b1;
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
                        if (open_q[i] && rxCnt_q[i] != PktSzW'(1)) errSet[i] = 1'b1;
                        rxCnt_d[i] = '0;
`endif
                        open_d[i] = 1'b0;
                    end
                    default: errSet[i] = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rxFull_q <= 1'b0;
            rxData_q <= '0;
            rxVc_q   <= '0;
            rxLast_q <= 1'b0;
            open_q   <= '0;
            rxErr_q  <= '0;
        end else begin
            if (rxAccept) begin
                rxFull_q <= 1'b1;
                rxData_q <= rxPayload;
                rxVc_q   <= noc_rx_vc;
                rxLast_q <= rxLastNew;
            end else if (rx_ready) begin
                rxFull_q <= 1'b0;
            end
            open_q  <= open_d;
            // A new error in the same cycle as its clear must survive.
            rxErr_q <= (rxErr_q & ~err_clr) | errSet;
        end
    end

`ifdef FLIT_PKT_SZ_IN_HEAD_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NumVc; i++) rxCnt_q[i] <= '0;
        end else begin
            rxCnt_q <= rxCnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_flit_engine.sv
// Directed scoreboard bench for pkt_flit_engine covering TX packetising, backpressure, RX framing errors and reset.
module tb_pkt_flit_engine;
    import ravenoc_pkg::*;

    localparam int FlitDataW = 32;
    localparam int NumVc     = 3;
    localparam int PktSzW    = 8;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] tx_data = '0;
    logic [1:0]  tx_vc = '0;
    logic [7:0]  tx_pkt_sz = '0;
    logic        noc_tx_valid;
    logic        noc_tx_ready = 1'b1;
    logic [33:0] noc_tx_flit;
    logic [1:0]  noc_tx_vc;
    logic        noc_rx_valid = 1'b0;
    logic        noc_rx_ready;
    logic [33:0] noc_rx_flit = '0;
    logic [1:0]  noc_rx_vc = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic [31:0] rx_data;
    logic [1:0]  rx_vc;
    logic        rx_last;
    logic [2:0]  rx_err;
    logic [2:0]  err_clr = '0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [35:0] txQ[$];
    logic [34:0] rxQ[$];
    logic        prevStall = 1'b0;
    logic [35:0] prevOut = '0;

    always #5 clk = ~clk;

    pkt_flit_engine #(
        .FlitDataW(FlitDataW), .NumVc(NumVc), .PktSzW(PktSzW)
    ) dut (
        .clk(clk), .arst(arst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_vc(tx_vc), .tx_pkt_sz(tx_pkt_sz),
        .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
        .noc_tx_flit(noc_tx_flit), .noc_tx_vc(noc_tx_vc),
        .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
        .noc_rx_flit(noc_rx_flit), .noc_rx_vc(noc_rx_vc),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_vc(rx_vc), .rx_last(rx_last), .rx_err(rx_err), .err_clr(err_clr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] txExp(input flit_type_t t, input logic [31:0] data,
                                          input logic [7:0] sz, input logic [1:0] vc);
        logic [31:0] p;
        p = data;
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
        if (t == FLIT_HEAD) p[31:24] = (sz == 8'd0) ? 8'd1 : sz;
`endif
        return {t, p, vc};
    endfunction

    // Drives one TX beat (entered at posedge+1), records its expected flit on acceptance.
    task automatic applyStimulus(input logic [1:0] vcIn, input logic [7:0] sz,
                                 input logic [31:0] data, input logic [35:0] expFlit);
        int waits;
        waits     = 0;
        tx_valid  = 1'b1;
        tx_vc     = vcIn;
        tx_pkt_sz = sz;
        tx_data   = data;
        @(negedge clk);
        while (!tx_ready && waits < 60) begin
            waits++;
            @(negedge clk);
        end
        checkOutput("tx_accept_wait", tx_ready, 1);
        txQ.push_back(expFlit);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic sendPacket(input logic [1:0] vc, input logic [7:0] sz, input logic [31:0] base);
        int n;
        n = (sz == 8'd0) ? 1 : int'(sz);
        for (int k = 0; k < n; k++) begin
            flit_type_t t;
            logic [1:0] vcDrive;
            logic [7:0] szDrive;
            t       = (k == 0) ? FLIT_HEAD : ((k == n - 1) ? FLIT_TAIL : FLIT_BODY);
            vcDrive = (k == 0) ? vc : ((vc == 2'd2) ? 2'd0 : vc + 2'd1);
            szDrive = (k == 0) ? sz : 8'hFF;
            applyStimulus(vcDrive, szDrive, base + k, txExp(t, base + k, sz, vc));
        end
    endtask

    task automatic sendRxFlit(input logic [1:0] vc, input flit_type_t t,
                              input logic [31:0] payload, input logic [2:0] clr);
        int   waits;
        logic expLast;
        waits        = 0;
        noc_rx_valid = 1'b1;
        noc_rx_vc    = vc;
        noc_rx_flit  = {t, payload};
        err_clr      = clr;
        @(negedge clk);
        while (!noc_rx_ready && waits < 60) begin
            waits++;
            @(negedge clk);
        end
        checkOutput("rx_accept_wait", noc_rx_ready, 1);
        expLast = (t == FLIT_TAIL);
`ifdef FLIT_PKT_SZ_IN_HEAD_EN
        if (t == FLIT_HEAD && payload[31:24] <= 8'd1) expLast = 1'b1;
`endif
        rxQ.push_back({payload, vc, expLast});
        @(posedge clk);
        #1;
        noc_rx_valid = 1'b0;
        err_clr      = '0;
    endtask

    task automatic waitDrain(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while ((txQ.size() != 0 || rxQ.size() != 0) && w < 200) begin
            w++;
            @(negedge clk);
        end
        checkOutput({tag, "_txq_empty"}, txQ.size(), 0);
        checkOutput({tag, "_rxq_empty"}, rxQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitors: scoreboard pops on handshakes plus stall-stability tracking.
    always @(negedge clk) begin
        if (arst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) checkOutput("tx_stable", {noc_tx_flit, noc_tx_vc}, prevOut);
            prevStall = noc_tx_valid && !noc_tx_ready;
            prevOut   = {noc_tx_flit, noc_tx_vc};
            if (noc_tx_valid && noc_tx_ready) begin
                checkOutput("tx_sb_nonempty", txQ.size() != 0, 1);
                if (txQ.size() != 0) checkOutput("tx_flit", {noc_tx_flit, noc_tx_vc}, txQ.pop_front());
            end
            if (rx_valid && rx_ready) begin
                checkOutput("rx_sb_nonempty", rxQ.size() != 0, 1);
                if (rxQ.size() != 0) checkOutput("rx_flit", {rx_data, rx_vc, rx_last}, rxQ.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_noc_tx_valid", noc_tx_valid, 0);
        checkOutput("rst_noc_rx_ready", noc_rx_ready, 1);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_err", rx_err, 0);
        checkOutput("rst_noc_tx_flit", {noc_tx_flit, noc_tx_vc}, 0);
        checkOutput("rst_rx_data", {rx_data, rx_vc, rx_last}, 0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Four-flit packet on VC1 streams one flit per cycle after one cycle.
        sendPacket(2'd1, 8'd4, 32'h1000_0000);
        checkOutput("stream_inflight", txQ.size(), 1);
        checkOutput("stream_valid", noc_tx_valid, 1);
        waitDrain("pkt4");

        // Zero and one sized packets are HEAD only; the following packet starts fresh.
        sendPacket(2'd0, 8'd0, 32'h2000_0000);
        sendPacket(2'd2, 8'd1, 32'h2100_0000);
        sendPacket(2'd0, 8'd3, 32'h2200_0000);
        waitDrain("single");

        // NoC stall mid-packet: two beats buffered then tx_ready drops.
        noc_tx_ready = 1'b0;
        fork
            sendPacket(2'd2, 8'd6, 32'h3000_0000);
            begin
                repeat (5) @(negedge clk);
                checkOutput("stall_tx_ready", tx_ready, 0);
                checkOutput("stall_noc_valid", noc_tx_valid, 1);
                checkOutput("stall_buffered", txQ.size(), 2);
                @(posedge clk);
                #1;
                noc_tx_ready = 1'b1;
            end
        join
        waitDrain("stall");

        // BODY on a closed VC flags its error; clear works, clear loses to a new error.
        sendRxFlit(2'd2, FLIT_BODY, 32'hB0D1_0002, 3'b000);
        checkOutput("err_body_closed", rx_err, 3'b100);
        err_clr = 3'b100;
        @(posedge clk);
        #1;
        err_clr = 3'b000;
        checkOutput("err_cleared", rx_err, 3'b000);
        sendRxFlit(2'd2, FLIT_BODY, 32'hB0D1_0003, 3'b000);
        sendRxFlit(2'd2, FLIT_BODY, 32'hB0D1_0004, 3'b100);
        checkOutput("err_set_wins", rx_err, 3'b100);
        err_clr = 3'b100;
        @(posedge clk);
        #1;
        err_clr = 3'b000;

        // Reserved type and HEAD on an open VC both flag, flits still forwarded.
        sendRxFlit(2'd0, FLIT_RSVD, 32'h0000_0011, 3'b000);
        checkOutput("err_rsvd", rx_err, 3'b001);
        sendRxFlit(2'd1, FLIT_HEAD, 32'h0200_0001, 3'b000);
        checkOutput("err_head_ok", rx_err, 3'b001);
        sendRxFlit(2'd1, FLIT_HEAD, 32'h0200_0002, 3'b000);
        sendRxFlit(2'd1, FLIT_TAIL, 32'h0000_0003, 3'b000);
        checkOutput("err_head_open", rx_err, 3'b011);
        err_clr = 3'b011;
        @(posedge clk);
        #1;
        err_clr = 3'b000;
        waitDrain("rxerr");

        // Interleaved VC0/VC1 packets with a toggling sink.
        fork
            begin
                sendRxFlit(2'd0, FLIT_HEAD, 32'h0300_00A0, 3'b000);
                sendRxFlit(2'd1, FLIT_HEAD, 32'h0200_00B0, 3'b000);
                sendRxFlit(2'd0, FLIT_BODY, 32'h0000_00A1, 3'b000);
                sendRxFlit(2'd1, FLIT_TAIL, 32'h0000_00B1, 3'b000);
                sendRxFlit(2'd0, FLIT_TAIL, 32'h0000_00A2, 3'b000);
            end
            begin
                repeat (11) begin
                    @(posedge clk);
                    #1;
                    rx_ready = ~rx_ready;
                end
                rx_ready = 1'b1;
            end
        join
        waitDrain("interleave");
        checkOutput("interleave_no_err", rx_err, 3'b000);

        // Reset mid-packet drops buffered flits; the next packet begins with HEAD.
        noc_tx_ready = 1'b0;
        applyStimulus(2'd1, 8'd4, 32'h4000_0000, txExp(FLIT_HEAD, 32'h4000_0000, 8'd4, 2'd1));
        applyStimulus(2'd1, 8'd4, 32'h4000_0001, txExp(FLIT_BODY, 32'h4000_0001, 8'd4, 2'd1));
        arst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_noc_tx_valid", noc_tx_valid, 0);
        checkOutput("mid_rst_tx_ready", tx_ready, 1);
        checkOutput("mid_rst_noc_tx_flit", {noc_tx_flit, noc_tx_vc}, 0);
        checkOutput("mid_rst_rx", {rx_valid, noc_rx_ready, rx_err}, {1'b0, 1'b1, 3'b000});
        txQ.delete();
        rxQ.delete();
        @(posedge clk);
        #1;
        arst = 1'b0;
        noc_tx_ready = 1'b1;
        sendPacket(2'd1, 8'd2, 32'h5000_0000);
        waitDrain("post_rst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
